// File: rtl/sfifo_gen_pkg.sv
// Shared helpers for sfifo_gen: derived widths, default thresholds, parameter legality.
package sfifo_gen_pkg;

  localparam int DEFAULT_DEPTH     = 16;
  localparam int DEFAULT_AE_THRESH = 2;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count needs one extra bit so that a completely full FIFO (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af_thresh, input int ae_thresh);
    return (data_w >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sfifo_gen_ram.sv
// Simple dual-port storage for sfifo_gen: one write port, one registered read port.
module sfifo_gen_ram
  import sfifo_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [addr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  input  logic [addr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; a read of the address being written returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sfifo_gen.sv
// Parametrised single-clock FIFO with occupancy count, programmable flags and sticky errors.
// Define SFIFO_GEN_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module sfifo_gen
  import sfifo_gen_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = DEFAULT_AE_THRESH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     r_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
    $error("sfifo_gen: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [PTR_W-1:0]  wptr_reg, rptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              full_reg, empty_reg, af_reg, ae_reg, ovf_reg, udf_reg;
  logic              empty_next, ovf_next, udf_next;
  logic              rd_acc, wr_acc, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // A read needs a visible word; a write into a full FIFO is fine only if a read frees a slot.
  assign rd_acc = r_en && !empty_reg;
  assign wr_acc = w_en && (!full_reg || rd_acc);

`ifdef SFIFO_GEN_FWFT_EN
  logic ram_has;
  // The RAM output register is the prefetch stage; refill it whenever it is idle or being popped.
  assign ram_has    = (wptr_reg != rptr_reg);
  assign ram_re     = ram_has && (empty_reg || rd_acc);
  assign empty_next = !(ram_re || (!empty_reg && !rd_acc));
`else
  assign ram_re     = rd_acc;
  assign empty_next = (count_next == '0);
`endif

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc)      count_next = count_reg + CNT_W'(1);
    else if (rd_acc && !wr_acc) count_next = count_reg - CNT_W'(1);
  end

  // New errors win over a clear arriving in the same cycle.
  always_comb begin
    ovf_next = ovf_reg;
    udf_next = udf_reg;
    if (clr_err) begin
      ovf_next = 1'b0;
      udf_next = 1'b0;
    end
    if (w_en && !wr_acc) ovf_next = 1'b1;
    if (r_en && !rd_acc) udf_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      af_reg    <= 1'b0;
      ae_reg    <= 1'b1;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      if (wr_acc) wptr_reg <= wptr_reg + PTR_W'(1);
      if (ram_re) rptr_reg <= rptr_reg + PTR_W'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_C);
      empty_reg <= empty_next;
      af_reg    <= (count_next >= AF_C);
      ae_reg    <= (count_next <= AE_C);
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  sfifo_gen_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr_reg[ADDR_W-1:0]),
    .wdata (din),
    .re    (ram_re),
    .raddr (rptr_reg[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign dout         = ram_rdata;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign count        = count_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;

endmodule

// File: tb/tb_sfifo_gen.sv
// Directed bench for sfifo_gen: a DEPTH=4 and a DEPTH=16 instance share one stimulus stream.
module tb_sfifo_gen;

  logic       clk = 1'b0;
  logic       rst, w_en, r_en, clr_err;
  logic [7:0] din;

  logic [7:0] d4_dout;
  logic       d4_full, d4_empty, d4_af, d4_ae, d4_ovf, d4_udf;
  logic [2:0] d4_count;

  logic [7:0] d16_dout;
  logic       d16_full, d16_empty, d16_af, d16_ae, d16_ovf, d16_udf;
  logic [4:0] d16_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sfifo_gen #(.DATA_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .clr_err(clr_err),
    .dout(d4_dout), .full(d4_full), .empty(d4_empty), .almost_full(d4_af),
    .almost_empty(d4_ae), .count(d4_count), .overflow(d4_ovf), .underflow(d4_udf)
  );

  sfifo_gen #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut16 (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .clr_err(clr_err),
    .dout(d16_dout), .full(d16_full), .empty(d16_empty), .almost_full(d16_af),
    .almost_empty(d16_ae), .count(d16_count), .overflow(d16_ovf), .underflow(d16_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    w_en = w; din = d; r_en = r; clr_err = c;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; din = 8'h00;
    $display("txn w_en=%0d din=%02h r_en=%0d clr=%0d | d4 cnt=%0d dout=%02h e=%0d f=%0d ov=%0d un=%0d | d16 cnt=%0d dout=%02h",
             w, d, r, c, d4_count, d4_dout, d4_empty, d4_full, d4_ovf, d4_udf, d16_count, d16_dout);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_d4_reset(input string tag);
    chk({tag, "_count"}, 32'(d4_count), 32'd0);
    chk({tag, "_empty"}, 32'(d4_empty), 32'd1);
    chk({tag, "_full"},  32'(d4_full),  32'd0);
    chk({tag, "_ae"},    32'(d4_ae),    32'd1);
    chk({tag, "_af"},    32'(d4_af),    32'd0);
    chk({tag, "_ovf"},   32'(d4_ovf),   32'd0);
    chk({tag, "_udf"},   32'(d4_udf),   32'd0);
    chk({tag, "_dout"},  32'(d4_dout),  32'h00);
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; din = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_d4_reset("rst");
    rst = 1'b0;

`ifndef SFIFO_GEN_FWFT_EN
    // 1: streaming, one-cycle registered read latency
    cyc(1'b1, 8'h75, 1'b0, 1'b0);
    chk("t1_cnt1",  32'(d4_count), 32'd1);
    chk("t1_empty", 32'(d4_empty), 32'd0);
    cyc(1'b1, 8'h76, 1'b1, 1'b0);
    chk("t1_rd75",  32'(d4_dout),  32'h75);
    chk("t1_cnt_wr", 32'(d4_count), 32'd1);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t1_rd76",  32'(d4_dout),  32'h76);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_rd77",  32'(d4_dout),  32'h77);
    chk("t1_empty2", 32'(d4_empty), 32'd1);
    cyc(1'b1, 8'h78, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_rd78",  32'(d4_dout),  32'h78);
    chk("t1_empty3", 32'(d4_empty), 32'd1);
    chk("t1_ovf",   32'(d4_ovf),   32'd0);
    chk("t1_udf",   32'(d4_udf),   32'd0);

    // 2: fill to full, rejected fifth write, sticky overflow
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      chk("t2_full_fill", 32'(d4_full), (i == 3) ? 32'd1 : 32'd0);
    end
    cyc(1'b1, 8'h14, 1'b0, 1'b0);
    chk("t2_cnt4",  32'(d4_count), 32'd4);
    chk("t2_ovf",   32'(d4_ovf),   32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_ovf_sticky", 32'(d4_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_rd", 32'(d4_dout), 32'h10 + 32'(i));
    end
    chk("t2_empty", 32'(d4_empty), 32'd1);

    // 3: underflow, clear, and set-beats-clear
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(d4_ovf), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_udf",     32'(d4_udf),  32'd1);
    chk("t3_dout_hold", 32'(d4_dout), 32'h13);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_udf_clr", 32'(d4_udf),  32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t3_udf_prio", 32'(d4_udf), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_udf_sticky", 32'(d4_udf), 32'd1);

    // 4: simultaneous read/write on a full FIFO, then drain across the wrap
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("t4_cnt",  32'(d4_count), 32'd4);
    chk("t4_dout", 32'(d4_dout),  32'hA0);
    chk("t4_ovf",  32'(d4_ovf),   32'd0);
    chk("t4_full", 32'(d4_full),  32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t4_drain", 32'(d4_dout), 32'hA0 + 32'(i));
    end
    chk("t4_empty", 32'(d4_empty), 32'd1);

    // 5: DEPTH=16 almost-full/almost-empty thresholds
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      cyc(1'b1, 8'h20 + 8'(k), 1'b0, 1'b0);
      chk("t5_cnt_up", 32'(d16_count), 32'(k));
      chk("t5_af_up",  32'(d16_af), (k >= 14) ? 32'd1 : 32'd0);
      chk("t5_ae_up",  32'(d16_ae), (k <= 2)  ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_rd",      32'(d16_dout), 32'h20 + 32'(k));
      chk("t5_af_down", 32'(d16_af),   32'd0);
      chk("t5_ae_down", 32'(d16_ae),   (14 - k <= 2) ? 32'd1 : 32'd0);
    end
    chk("t5_cnt2",  32'(d16_count), 32'd2);
    chk("t5_full",  32'(d16_full),  32'd0);
    chk("t5_empty", 32'(d16_empty), 32'd0);
    chk("t5_ovf",   32'(d16_ovf),   32'd0);
    chk("t5_udf",   32'(d16_udf),   32'd0);

    // 6: asynchronous reset in the middle of operation
    do_reset();
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h34, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h35, 1'b0, 1'b0);
    chk("t6_pre_dout", 32'(d4_dout), 32'h34);
    chk("t6_pre_udf",  32'(d4_udf),  32'd1);
    #2 rst = 1'b1;
    #1 chk_d4_reset("t6_async");
    @(posedge clk); #1;
    rst = 1'b0;
`else
    // FWFT: one-cycle prefetch, head word visible without r_en
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("f_empty_n",  32'(d4_empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("f_empty_n1", 32'(d4_empty), 32'd0);
    chk("f_dout",     32'(d4_dout),  32'h55);
    chk("f_cnt",      32'(d4_count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("f_pop_empty", 32'(d4_empty), 32'd1);
    chk("f_pop_cnt",   32'(d4_count), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("f_udf",       32'(d4_udf),   32'd1);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    cyc(1'b1, 8'h67, 1'b0, 1'b0);
    chk("f_head",      32'(d4_dout),  32'h66);
    chk("f_cnt2",      32'(d4_count), 32'd2);
    #2 rst = 1'b1;
    #1 chk_d4_reset("f_async");
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
